// File: rtl/sar_adc_pkg.sv
// Shared types and defaults for the SAR ADC host sequencer.
package sar_adc_pkg;

    localparam int unsigned DEF_N_BITS         = 10;
    localparam int unsigned DEF_AVG_LOG2       = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        WAIT_EOC,
        RECOVER,
        OUTPUT,
        ABORT
    } state_t;

    // Sum of 2^avg_log2 unsigned n_bits samples needs avg_log2 extra bits.
    function automatic int unsigned acc_width(input int unsigned n_bits,
                                              input int unsigned avg_log2);
        return n_bits + avg_log2;
    endfunction

endpackage

// File: rtl/sar_adc_host_if.sv
// ADC handshake (hold/eoc/result) plus the averaged valid/ready result stream.
interface sar_adc_host_if import sar_adc_pkg::*; #(
    parameter int unsigned N_BITS = DEF_N_BITS
);
    logic              input_hold_digital;
    logic              eoc;
    logic [N_BITS-1:0] adc_result;
    logic [N_BITS-1:0] result_data;
    logic              result_valid;
    logic              result_ready;

    // Host side: drives hold and the result stream.
    modport master (
        output input_hold_digital,
        input  eoc,
        input  adc_result,
        output result_data,
        output result_valid,
        input  result_ready
    );

    // ADC / consumer side.
    modport slave (
        input  input_hold_digital,
        output eoc,
        output adc_result,
        input  result_data,
        input  result_valid,
        output result_ready
    );
endinterface

// File: rtl/sar_avg_accum.sv
// Burst accumulator: sums samples, counts them, and presents the truncated mean.
module sar_avg_accum import sar_adc_pkg::*; #(
    parameter int unsigned N_BITS   = DEF_N_BITS,
    parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add,
    input  logic [N_BITS-1:0] sample,
    output logic              done,
    output logic [N_BITS-1:0] avg
);
    localparam int unsigned      ACC_W    = acc_width(N_BITS, AVG_LOG2);
    localparam int unsigned      CNT_W    = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << AVG_LOG2;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over add; the FSM never adds past a full burst.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add) begin
            acc_d = acc_q + ACC_W'(sample);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Accumulator and sample-count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_FULL);
    assign avg  = N_BITS'(acc_q >> AVG_LOG2);

endmodule

// File: rtl/sar_adc_host.sv
// SAR ADC conversion sequencer: hold/eoc timing, timeout abort, burst averaging
// and a valid/ready result port with backpressure.
module sar_adc_host import sar_adc_pkg::*; #(
    parameter int unsigned N_BITS         = DEF_N_BITS,
    parameter int unsigned AVG_LOG2       = DEF_AVG_LOG2,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           continuous,
    output logic           busy,
    output logic           timeout_err,
    sar_adc_host_if.master adc
);
    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              hold_q, hold_d;
    logic [N_BITS-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              eoc_q;

    logic              eoc_rise;
    logic              acc_clear;
    logic              acc_add;
    logic              acc_done;
    logic [N_BITS-1:0] acc_avg;

    assign eoc_rise = adc.eoc & ~eoc_q;

    sar_avg_accum #(
        .N_BITS   (N_BITS),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk    (clk),
        .reset  (reset),
        .clear  (acc_clear),
        .add    (acc_add),
        .sample (adc.adc_result),
        .done   (acc_done),
        .avg    (acc_avg)
    );

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        data_d    = data_q;
        valid_d   = valid_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_clear = 1'b1;
                    err_d     = 1'b0;
                    hold_d    = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                // Hold stays high into WAIT_EOC; timeout starts fresh there.
                tmo_d   = '0;
                state_d = WAIT_EOC;
            end
            WAIT_EOC: begin
                tmo_d = tmo_q + TMO_W'(1);
                // A rise on the final allowed cycle still counts as a sample.
                if (eoc_rise) begin
                    acc_add = 1'b1;
                    hold_d  = 1'b0;
                    tmo_d   = '0;
                    state_d = RECOVER;
                end else if (tmo_q == TMO_LAST) begin
                    hold_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ABORT;
                end
            end
            RECOVER: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (!adc.eoc) begin
                    if (acc_done) begin
                        data_d  = acc_avg;
                        valid_d = 1'b1;
                        state_d = OUTPUT;
                    end else begin
                        hold_d  = 1'b1;
                        state_d = HOLD;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ABORT;
                end
            end
            OUTPUT: begin
                // valid is always high here, so ready alone completes the handshake.
                if (adc.result_ready) begin
                    valid_d = 1'b0;
                    if (continuous) begin
                        acc_clear = 1'b1;
                        hold_d    = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            ABORT: begin
                acc_clear = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                hold_d  = 1'b0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Sequencer state, registered outputs, timeout counter and eoc edge history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hold_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            eoc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            eoc_q   <= adc.eoc;
        end
    end

    assign adc.input_hold_digital = hold_q;
    assign adc.result_data        = data_q;
    assign adc.result_valid       = valid_q;
    assign busy                   = busy_q;
    assign timeout_err            = err_q;

endmodule

// File: tb/tb_sar_adc_host.sv
// Randomised bench for sar_adc_host: a behavioural ADC driver feeds samples,
// a queue-based model predicts each burst mean, and timing rules are checked.
module tb_sar_adc_host;
    import sar_adc_pkg::*;

    localparam int unsigned NB    = 10;
    localparam int unsigned AVG_A = 2;
    localparam int unsigned TMO   = 64;
    localparam int          NCONV = 1 << AVG_A;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start_a = 1'b0, cont_a = 1'b0, busy_a, err_a;
    logic start_b = 1'b0, cont_b = 1'b0, busy_b, err_b;

    sar_adc_host_if #(.N_BITS(NB)) bus_a ();
    sar_adc_host_if #(.N_BITS(NB)) bus_b ();

    sar_adc_host #(.N_BITS(NB), .AVG_LOG2(AVG_A), .TIMEOUT_CYCLES(TMO)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .start       (start_a),
        .continuous  (cont_a),
        .busy        (busy_a),
        .timeout_err (err_a),
        .adc         (bus_a)
    );

    sar_adc_host #(.N_BITS(NB), .AVG_LOG2(0), .TIMEOUT_CYCLES(TMO)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .start       (start_b),
        .continuous  (cont_b),
        .busy        (busy_b),
        .timeout_err (err_b),
        .adc         (bus_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [NB-1:0] samples[$];

    // Rising edges of hold on DUT A, counted at the sampling edge.
    int   hold_rises = 0;
    logic hold_prev  = 1'b0;
    always @(negedge clk) begin
        hold_prev <= bus_a.input_hold_digital;
        if (bus_a.input_hold_digital && !hold_prev) hold_rises <= hold_rises + 1;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One ADC conversion: wait for hold, answer after dly cycles, keep eoc high
    // for hi_len extra cycles. Called at a negedge; returns at a negedge.
    task automatic do_conv(input logic [NB-1:0] val, input int dly, input int hi_len,
                           input bit last);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b1;
        while (bus_a.input_hold_digital !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("hold_wait", int'(n < 100), 1);
        repeat (dly) tick();
        bus_a.eoc        = 1'b1;
        bus_a.adc_result = val;
        samples.push_back(val);
        tick();
        chk("hold_drop", int'(bus_a.input_hold_digital), 0);
        if (last) chk("valid_early", int'(bus_a.result_valid), 0);
        repeat (hi_len) begin
            tick();
            if (bus_a.input_hold_digital !== 1'b0 || bus_a.result_valid !== 1'b0) ok = 1'b0;
        end
        chk("hold_low_eoc", int'(ok), 1);
        bus_a.eoc        = 1'b0;
        bus_a.adc_result = NB'($urandom);
        tick();
        if (last) chk("valid_lat", int'(bus_a.result_valid), 1);
        else      chk("hold_next", int'(bus_a.input_hold_digital), 1);
    endtask

    // Compare the result against the model mean, apply backpressure, then accept.
    task automatic collect(input bit cont, input int rdy_dly);
        logic [NB-1:0] d0;
        int sum;
        int expv;
        bit ok;
        d0  = bus_a.result_data;
        sum = 0;
        foreach (samples[i]) sum += int'(samples[i]);
        expv = sum / NCONV;
        chk("avg_data", int'(d0), expv);
        samples.delete();
        ok = 1'b1;
        repeat (rdy_dly) begin
            tick();
            if (bus_a.result_valid !== 1'b1 || bus_a.result_data !== d0 ||
                bus_a.input_hold_digital !== 1'b0) ok = 1'b0;
        end
        if (rdy_dly > 0) chk("bp_stable", int'(ok), 1);
        bus_a.result_ready = 1'b1;
        cont_a             = cont;
        tick();
        bus_a.result_ready = 1'b0;
        chk("valid_drop", int'(bus_a.result_valid), 0);
        chk("next_hold", int'(bus_a.input_hold_digital), int'(cont));
        chk("busy_after", int'(busy_a), int'(cont));
    endtask

    task automatic run_burst(input bit do_start, input bit cont, input int rdy_dly);
        if (do_start) begin
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            chk("start_lat", int'(bus_a.input_hold_digital), 1);
        end
        for (int i = 0; i < NCONV; i++)
            do_conv(NB'($urandom), $urandom_range(1, 8), $urandom_range(0, 3), i == NCONV - 1);
        collect(cont, rdy_dly);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  h0;
        bit  idle;
        bit  cont;
        bus_a.eoc = 1'b0; bus_a.adc_result = '0; bus_a.result_ready = 1'b0;
        bus_b.eoc = 1'b0; bus_b.adc_result = '0; bus_b.result_ready = 1'b0;

        // Reset state
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_hold",  int'(bus_a.input_hold_digital), 0);
        chk("rst_data",  int'(bus_a.result_data), 0);
        chk("rst_valid", int'(bus_a.result_valid), 0);
        chk("rst_busy",  int'(busy_a), 0);
        chk("rst_err",   int'(err_a), 0);
        reset = 1'b1;
        tick();

        // No averaging: full-scale sample, valid two cycles after the eoc rise
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_start", int'(bus_b.input_hold_digital), 1);
        tick();
        bus_b.eoc = 1'b1;
        bus_b.adc_result = NB'(1023);
        tick();
        chk("b_hold_drop", int'(bus_b.input_hold_digital), 0);
        chk("b_valid_early", int'(bus_b.result_valid), 0);
        bus_b.eoc = 1'b0;
        tick();
        chk("b_valid", int'(bus_b.result_valid), 1);
        chk("b_data", int'(bus_b.result_data), 1023);
        bus_b.result_ready = 1'b1;
        tick();
        bus_b.result_ready = 1'b0;
        chk("b_valid_drop", int'(bus_b.result_valid), 0);
        chk("b_busy", int'(busy_b), 0);
        chk("b_err", int'(err_b), 0);

        // Directed burst 100..103 -> 101
        h0 = hold_rises;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("dir_start", int'(bus_a.input_hold_digital), 1);
        do_conv(NB'(100), 1, 0, 1'b0);
        do_conv(NB'(101), 3, 1, 1'b0);
        do_conv(NB'(102), 2, 2, 1'b0);
        do_conv(NB'(103), 1, 0, 1'b1);
        chk("dir_data", int'(bus_a.result_data), 101);
        collect(1'b0, 0);
        repeat (2) tick();
        chk("dir_pulses", hold_rises - h0, 4);

        // Random bursts, some chained through continuous mode
        idle = 1'b1;
        for (int b = 0; b < 6; b++) begin
            cont = (b < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_burst(idle, cont, $urandom_range(0, 4));
            idle = !cont;
        end

        // Backpressure with continuous=1 for 20 cycles, then a final burst
        run_burst(1'b1, 1'b1, 20);
        run_burst(1'b0, 1'b0, 0);

        // Timeout with no eoc
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (TMO) tick();
        chk("tmo_hold_pre", int'(bus_a.input_hold_digital), 1);
        chk("tmo_err_pre", int'(err_a), 0);
        tick();
        chk("tmo_hold_drop", int'(bus_a.input_hold_digital), 0);
        chk("tmo_err", int'(err_a), 1);
        chk("tmo_valid", int'(bus_a.result_valid), 0);
        tick();
        chk("tmo_idle", int'(busy_a), 0);
        repeat (3) tick();
        chk("tmo_sticky", int'(err_a), 1);
        chk("tmo_valid2", int'(bus_a.result_valid), 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("tmo_clear", int'(err_a), 0);
        for (int i = 0; i < NCONV; i++)
            do_conv(NB'($urandom), $urandom_range(1, 5), 0, i == NCONV - 1);
        collect(1'b0, 1);

        // eoc rise on the exact timeout cycle is accepted
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        do_conv(NB'($urandom), TMO, 0, 1'b0);
        for (int i = 1; i < NCONV; i++)
            do_conv(NB'($urandom), 2, 1, i == NCONV - 1);
        chk("edge_err", int'(err_a), 0);
        collect(1'b0, 0);

        // Asynchronous reset during WAIT_EOC of the third sample
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        do_conv(NB'($urandom), 2, 0, 1'b0);
        do_conv(NB'($urandom), 2, 0, 1'b0);
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_hold",  int'(bus_a.input_hold_digital), 0);
        chk("mid_rst_data",  int'(bus_a.result_data), 0);
        chk("mid_rst_valid", int'(bus_a.result_valid), 0);
        chk("mid_rst_busy",  int'(busy_a), 0);
        chk("mid_rst_err",   int'(err_a), 0);
        samples.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_busy", int'(busy_a), 0);
        run_burst(1'b1, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_adc_host.md
# sar_adc_host

Host-side conversion sequencer for the SAR ADC. It drives the ADC sample/hold request and watches end-of-conversion. It captures each N_BITS result, averages bursts of 2^AVG_LOG2 conversions, and presents the average on a valid/ready output. It sits between the ADC instance and the digital consumer and owns all conversion timing, timeout detection and backpressure.

## Interface
- N_BITS, 10, ADC result width
- AVG_LOG2, 2, log2 of conversions averaged per output word (0 = no averaging)
- TIMEOUT_CYCLES, 64, max clk cycles allowed in WAIT_EOC or RECOVER before abort
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  begin a burst; sampled only in IDLE
- continuous  in  1  1 = start the next burst automatically once the output is accepted
- input_hold_digital  out  1  sample/hold request to the ADC
- eoc  in  1  ADC end-of-conversion, synchronous to clk, level held high by the ADC
- adc_result  in  N_BITS  ADC output_result_digital
- result_data  out  N_BITS  averaged result
- result_valid  out  1  result_data valid; held until accepted
- result_ready  in  1  consumer accept
- busy  out  1  1 in any state other than IDLE
- timeout_err  out  1  sticky abort flag; cleared by the next accepted start

## Operation
- Reset values: input_hold_digital=0, result_data=0, result_valid=0, busy=0, timeout_err=0, state=IDLE, accumulator=0, sample count=0, timeout count=0, eoc_q=0.
- eoc rise = eoc & !eoc_q, where eoc_q is eoc registered every cycle.
- IDLE: if start=1, clear the accumulator and sample count, clear timeout_err, go to HOLD. All other inputs are ignored.
- HOLD: drive hold=1 for one cycle, go to WAIT_EOC. Hold stays 1 through WAIT_EOC.
- WAIT_EOC: increment the timeout count.
  - On eoc rise: add zero-extended adc_result to the accumulator, increment the sample count, set hold=0, go to RECOVER.
  - If the timeout count reaches TIMEOUT_CYCLES first: go to ABORT.
- RECOVER: hold=0. Wait for eoc=0, with the same timeout. Then:
  - if sample count = 2^AVG_LOG2, go to OUTPUT;
  - otherwise go to HOLD.
- OUTPUT: result_data = accumulator >> AVG_LOG2 (truncating), result_valid=1. On result_valid & result_ready:
  - continuous=1: clear accumulator and count, go to HOLD;
  - continuous=0: go to IDLE.
- ABORT (one cycle): hold=0, timeout_err=1, accumulator discarded, no result_valid, go to IDLE.
- Accumulator width is N_BITS+AVG_LOG2 bits and cannot overflow.
- The timeout count resets on every entry to WAIT_EOC and to RECOVER.

## Timing
- Start→hold latency: start high in IDLE at cycle t gives hold=1 at t+1.
- Capture: eoc rising at cycle t means adc_result is sampled at t and hold=0 at t+1.
- Hold is low for at least one cycle between conversions, and until eoc has fallen.
- Output latency: last eoc rise at t gives result_valid at t+2 at the earliest (eoc already low).
- result_data is stable while result_valid=1. Deasserting result_ready never drops valid.
- Simultaneous eoc rise and timeout limit: eoc wins, and the sample is taken.
- start while busy is ignored. result_ready while not valid is ignored.
- continuous is sampled only at the output handshake.
- Asynchronous reset mid-burst: all outputs go to their reset values immediately. The partial burst is lost and no result is emitted.

## Structure
- Package sar_adc_pkg:
  - state enum {IDLE, HOLD, WAIT_EOC, RECOVER, OUTPUT, ABORT};
  - default N_BITS, AVG_LOG2, TIMEOUT_CYCLES constants;
  - accumulator width function.
- Sub-module sar_avg_accum: accumulator, sample counter and shift, with clear/add/done ports. The FSM stays in sar_adc_host.

## Test plan
- Single burst, AVG_LOG2=2, continuous=0: ADC returns 100, 101, 102, 103 → one result_valid with result_data=101, then busy=0 and four hold pulses seen.
- AVG_LOG2=0, adc_result=1023 → result_data=1023, valid 2 cycles after eoc rise; hold is low for at least one cycle.
- No eoc, TIMEOUT_CYCLES=64 → hold drops and timeout_err=1 64 cycles after entering WAIT_EOC; result_valid never rises; the next start clears timeout_err.
- Backpressure: continuous=1 with result_ready held low for 20 cycles → result_valid and result_data stable, hold stays 0, and the next burst starts the cycle after the handshake.
- eoc rise on the exact timeout cycle → sample accepted, timeout_err stays 0.
- reset asserted during WAIT_EOC of sample 3 → all outputs at reset values the same cycle; after release and start, a fresh burst of 4 averages only new samples.
